// File: rtl/pdp8_io_pkg.sv
// Shared PDP-8 I/O definitions: device codes, IOT operation encodings,
// CPU major states and the UART FSM state types.
package pdp8_io_pkg;

  localparam logic [5:0] KBD_DEV = 6'o03;
  localparam logic [5:0] TTY_DEV = 6'o04;

  typedef enum logic [3:0] {
    CPU_FETCH   = 4'd0,
    CPU_EXECUTE = 4'd1,
    CPU_DEFER   = 4'd2,
    CPU_WORDCNT = 4'd3,
    CPU_CURADDR = 4'd4,
    CPU_BREAK   = 4'd5
  } cpu_state_e;

  localparam logic [3:0] IOT_EXEC_STATE = 4'd1;

  // Keyboard operations (mb[2:0])
  localparam logic [2:0] OP_KCF = 3'd0;
  localparam logic [2:0] OP_KSF = 3'd1;
  localparam logic [2:0] OP_KCC = 3'd2;
  localparam logic [2:0] OP_KRS = 3'd4;
  localparam logic [2:0] OP_KIE = 3'd5;
  localparam logic [2:0] OP_KRB = 3'd6;

  // Printer operations (mb[2:0])
  localparam logic [2:0] OP_TFL = 3'd0;
  localparam logic [2:0] OP_TSF = 3'd1;
  localparam logic [2:0] OP_TCF = 3'd2;
  localparam logic [2:0] OP_TPC = 3'd4;
  localparam logic [2:0] OP_TSK = 3'd5;
  localparam logic [2:0] OP_TLS = 3'd6;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_ARMED = 2'd1,
    TX_SEND  = 2'd2
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/pdp8_tty_ctrl_if.sv
// CPU-side IOT bus between the processor io mux and the teletype controller.
interface pdp8_tty_ctrl_if;
  logic        iot;
  logic [3:0]  state;
  logic [11:0] mb;
  logic [5:0]  io_select;
  logic [11:0] io_data_in;
  logic        io_selected;
  logic [11:0] io_data_out;
  logic        io_data_avail;
  logic        io_interrupt;
  logic        io_skip;

  modport master (
    output iot, state, mb, io_select, io_data_in,
    input  io_selected, io_data_out, io_data_avail, io_interrupt, io_skip
  );

  modport slave (
    input  iot, state, mb, io_select, io_data_in,
    output io_selected, io_data_out, io_data_avail, io_interrupt, io_skip
  );
endinterface

// File: rtl/pdp8_uart8n1.sv
// 8N1 serial transmitter/receiver advanced only on brgclk enable pulses
// (OVS pulses per bit); the receiver samples at bit midpoints.
module pdp8_uart8n1
  import pdp8_io_pkg::*;
#(
  parameter int OVS = OVERSAMPLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       brgclk_i,
  input  logic       tx_load_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       uart_out_o,
  input  logic       uart_in_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o
);
  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(OVS - 1);
  localparam logic [CW-1:0] HALF = CW'(OVS / 2 - 1);

  tx_state_e tx_state_q, tx_state_d;
  logic [9:0] tx_shift_q, tx_shift_d;
  logic [CW-1:0] tx_tick_q, tx_tick_d;
  logic [3:0] tx_bit_q, tx_bit_d;
  logic tx_out_q, tx_out_d;

  rx_state_e rx_state_q, rx_state_d;
  logic rx_sync1_q, rx_sync2_q, rx_last_q, rx_last_d;
  logic [CW-1:0] rx_tick_q, rx_tick_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;

  // State registers for both directions plus the receive synchronizer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= 10'h3FF;
      tx_tick_q  <= ZERO;
      tx_bit_q   <= 4'd0;
      tx_out_q   <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_last_q  <= 1'b1;
      rx_tick_q  <= ZERO;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_out_q   <= tx_out_d;
      rx_state_q <= rx_state_d;
      rx_sync1_q <= uart_in_i;
      rx_sync2_q <= rx_sync1_q;
      rx_last_q  <= rx_last_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Transmit FSM: a load arms the frame, the next tick drives the start bit
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_out_d   = tx_out_q;
    tx_done_o  = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_load_i) begin
          tx_state_d = TX_ARMED;
          tx_shift_d = {1'b1, tx_data_i, 1'b0};
        end else begin
          tx_out_d = 1'b1;
        end
      end
      TX_ARMED: begin
        if (brgclk_i) begin
          tx_state_d = TX_SEND;
          tx_out_d   = tx_shift_q[0];
          tx_tick_d  = ZERO;
          tx_bit_d   = 4'd0;
        end else begin
          tx_state_d = TX_ARMED;
        end
      end
      TX_SEND: begin
        if (brgclk_i && tx_tick_q == LAST) begin
          tx_tick_d = ZERO;
          if (tx_bit_q == 4'd9) begin
            tx_state_d = TX_IDLE;
            tx_out_d   = 1'b1;
            tx_done_o  = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            tx_out_d   = tx_shift_q[1];
          end
        end else if (brgclk_i) begin
          tx_tick_d = tx_tick_q + ONE;
        end else begin
          tx_tick_d = tx_tick_q;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Receive FSM: start edge, mid-start re-check, mid-bit data and stop samples
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_last_d  = rx_last_q;
    rx_valid_o = 1'b0;
    if (brgclk_i) begin
      rx_last_d = rx_sync2_q;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_last_q && !rx_sync2_q) begin
            rx_state_d = RX_START;
            rx_tick_d  = ZERO;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end
        RX_START: begin
          if (rx_tick_q != HALF) begin
            rx_tick_d = rx_tick_q + ONE;
          end else if (rx_sync2_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_tick_d  = ZERO;
            rx_bit_d   = 3'd0;
          end
        end
        RX_DATA: begin
          if (rx_tick_q == LAST) begin
            rx_tick_d  = ZERO;
            rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) begin
              rx_state_d = RX_STOP;
            end else begin
              rx_bit_d = rx_bit_q + 3'd1;
            end
          end else begin
            rx_tick_d = rx_tick_q + ONE;
          end
        end
        RX_STOP: begin
          if (rx_tick_q == LAST) begin
            rx_state_d = RX_IDLE;
            rx_valid_o = rx_sync2_q;
          end else begin
            rx_tick_d = rx_tick_q + ONE;
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end else begin
      rx_state_d = rx_state_q;
    end
  end

  assign tx_busy_o  = (tx_state_q != TX_IDLE);
  assign uart_out_o = tx_out_q;
  assign rx_data_o  = rx_shift_q;

endmodule

// File: rtl/pdp8_tty_ctrl.sv
// KL8E-style console teletype: keyboard (03) / printer (04) IOT decode,
// flags, interrupt enable, and the serial UART beneath them.
module pdp8_tty_ctrl
  import pdp8_io_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           brgclk,
  input  logic           uart_in,
  output logic           uart_out,
  pdp8_tty_ctrl_if.slave bus
);
  logic       kbd_sel_s, tty_sel_s, commit_s;
  logic [2:0] op_s;
  logic       rx_flag_q, rx_flag_d, tx_flag_q, tx_flag_d;
  logic       int_en_q, int_en_d, irq_q;
  logic [7:0] rx_buf_q, rx_buf_d;
  logic       tx_load_s, tx_busy_s, tx_done_s, rx_valid_s;
  logic [7:0] rx_data_s;
  logic       skip_s, avail_s;
  logic [11:0] dout_s;
  logic       unused_mb_s;

  assign op_s        = bus.mb[2:0];
  assign unused_mb_s = ^bus.mb[11:3];
  assign kbd_sel_s   = bus.iot && (bus.io_select == KBD_DEV);
  assign tty_sel_s   = bus.iot && (bus.io_select == TTY_DEV);
  assign commit_s    = (bus.state == IOT_EXEC_STATE);
  assign tx_load_s   = commit_s && tty_sel_s && !tx_busy_s &&
                       ((op_s == OP_TPC) || (op_s == OP_TLS));

  pdp8_uart8n1 #(.OVS(OVERSAMPLE)) u_uart (
    .clk        (clk),
    .reset      (reset),
    .brgclk_i   (brgclk),
    .tx_load_i  (tx_load_s),
    .tx_data_i  (bus.io_data_in[7:0]),
    .tx_busy_o  (tx_busy_s),
    .tx_done_o  (tx_done_s),
    .uart_out_o (uart_out),
    .uart_in_i  (uart_in),
    .rx_data_o  (rx_data_s),
    .rx_valid_o (rx_valid_s)
  );

  // Flag/enable next state; UART set events come last so they win over IOT clears
  always_comb begin
    rx_flag_d = rx_flag_q;
    tx_flag_d = tx_flag_q;
    int_en_d  = int_en_q;
    rx_buf_d  = rx_buf_q;
    if (commit_s && kbd_sel_s) begin
      case (op_s)
        OP_KCF, OP_KCC, OP_KRB: rx_flag_d = 1'b0;
        OP_KIE:                 int_en_d  = bus.io_data_in[0];
        default:                rx_flag_d = rx_flag_q;
      endcase
    end else if (commit_s && tty_sel_s) begin
      case (op_s)
        OP_TFL:         tx_flag_d = 1'b1;
        OP_TCF, OP_TLS: tx_flag_d = 1'b0;
        default:        tx_flag_d = tx_flag_q;
      endcase
    end else begin
      int_en_d = int_en_q;
    end
    if (rx_valid_s) begin
      rx_flag_d = 1'b1;
      rx_buf_d  = rx_data_s;
    end else begin
      rx_buf_d = rx_buf_q;
    end
    if (tx_done_s) begin
      tx_flag_d = 1'b1;
    end else begin
      tx_flag_d = tx_flag_d;
    end
  end

  // Flag, enable, receive buffer and interrupt registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_flag_q <= 1'b0;
      tx_flag_q <= 1'b0;
      int_en_q  <= 1'b1;
      rx_buf_q  <= 8'd0;
      irq_q     <= 1'b0;
    end else begin
      rx_flag_q <= rx_flag_d;
      tx_flag_q <= tx_flag_d;
      int_en_q  <= int_en_d;
      rx_buf_q  <= rx_buf_d;
      irq_q     <= int_en_d && (rx_flag_d || tx_flag_d);
    end
  end

  // Combinational skip / AC-load responses, live whenever the device is selected
  always_comb begin
    skip_s  = 1'b0;
    avail_s = 1'b0;
    dout_s  = 12'd0;
    if (kbd_sel_s) begin
      case (op_s)
        OP_KSF: skip_s = rx_flag_q;
        OP_KCC: avail_s = 1'b1;
        OP_KRS: begin
          avail_s = 1'b1;
          dout_s  = bus.io_data_in | {4'd0, rx_buf_q};
        end
        OP_KRB: begin
          avail_s = 1'b1;
          dout_s  = {4'd0, rx_buf_q};
        end
        default: skip_s = 1'b0;
      endcase
    end else if (tty_sel_s) begin
      case (op_s)
        OP_TSF:  skip_s = tx_flag_q;
        OP_TSK:  skip_s = rx_flag_q || tx_flag_q;
        default: skip_s = 1'b0;
      endcase
    end else begin
      skip_s = 1'b0;
    end
  end

  assign bus.io_selected   = kbd_sel_s || tty_sel_s;
  assign bus.io_skip       = skip_s;
  assign bus.io_data_avail = avail_s;
  assign bus.io_data_out   = dout_s;
  assign bus.io_interrupt  = irq_q;

endmodule

// File: tb/tb_pdp8_tty_ctrl.sv
// Directed bench for pdp8_tty_ctrl: IOT decode, flags, interrupt, serial TX/RX.
module tb_pdp8_tty_ctrl;
  logic clk, reset, brgclk, uart_in, uart_out;
  int   checks = 0;
  int   failures = 0;

  pdp8_tty_ctrl_if bus ();

  pdp8_tty_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .brgclk   (brgclk),
    .uart_in  (uart_in),
    .uart_out (uart_out),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud enable: one clk wide, every 8 clocks
  initial begin
    brgclk = 1'b0;
    forever begin
      repeat (7) @(negedge clk);
      brgclk = 1'b1;
      @(negedge clk);
      brgclk = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%o expected=%o", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (brgclk !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic iot_setup(input logic [5:0] dev, input logic [2:0] op, input logic [11:0] ac);
    @(negedge clk);
    bus.iot        = 1'b1;
    bus.state      = 4'd1;
    bus.mb         = {3'b110, dev, op};
    bus.io_select  = dev;
    bus.io_data_in = ac;
    #1;
  endtask

  task automatic iot_end();
    @(posedge clk);
    #1;
    bus.iot   = 1'b0;
    bus.state = 4'd0;
  endtask

  task automatic iot(input logic [5:0] dev, input logic [2:0] op, input logic [11:0] ac);
    iot_setup(dev, op, ac);
    iot_end();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    wait_ticks(1);
    for (int k = 0; k < 10; k++) begin
      uart_in = f[k];
      wait_ticks(16);
    end
    uart_in = 1'b1;
    wait_ticks(4);
  endtask

  initial begin
    logic [9:0] exp_frame;
    reset          = 1'b0;
    uart_in        = 1'b1;
    bus.iot        = 1'b0;
    bus.state      = 4'd0;
    bus.mb         = 12'd0;
    bus.io_select  = 6'd0;
    bus.io_data_in = 12'd0;
    #22;
    check("rst_uart_out", {11'd0, uart_out}, 12'd1);
    check("rst_irq", {11'd0, bus.io_interrupt}, 12'd0);
    check("rst_selected", {11'd0, bus.io_selected}, 12'd0);
    @(negedge clk);
    reset = 1'b1;

    iot_setup(6'o03, 3'd1, 12'd0);
    check("rst_ksf_skip", {11'd0, bus.io_skip}, 12'd0);
    check("kbd_selected", {11'd0, bus.io_selected}, 12'd1);
    iot_end();
    iot_setup(6'o04, 3'd1, 12'd0);
    check("rst_tsf_skip", {11'd0, bus.io_skip}, 12'd0);
    iot_end();
    iot_setup(6'o05, 3'd6, 12'o7777);
    check("other_selected", {11'd0, bus.io_selected}, 12'd0);
    check("other_avail", {11'd0, bus.io_data_avail}, 12'd0);
    iot_end();

    // TLS 0101: frame 0,1,0,0,0,0,0,1,0,1
    exp_frame = 10'b1010000010;
    iot_setup(6'o04, 3'd6, 12'o0101);
    check("tls_avail", {11'd0, bus.io_data_avail}, 12'd0);
    iot_end();
    wait_ticks(1);
    check("tx_start_edge", {11'd0, uart_out}, 12'd0);
    iot(6'o04, 3'd4, 12'o0377);
    wait_ticks(8);
    check("tx_bit0", {11'd0, uart_out}, {11'd0, exp_frame[0]});
    for (int k = 1; k < 10; k++) begin
      wait_ticks(16);
      check($sformatf("tx_bit%0d", k), {11'd0, uart_out}, {11'd0, exp_frame[k]});
    end
    wait_ticks(7);
    check("tx_irq_before_end", {11'd0, bus.io_interrupt}, 12'd0);
    wait_ticks(1);
    check("tx_irq_at_end", {11'd0, bus.io_interrupt}, 12'd1);
    check("tx_idle_after", {11'd0, uart_out}, 12'd1);
    iot_setup(6'o04, 3'd1, 12'd0);
    check("tsf_skip_done", {11'd0, bus.io_skip}, 12'd1);
    iot_end();

    // Receive 0x5A
    send_frame(8'h5A, 1'b1);
    iot_setup(6'o03, 3'd1, 12'd0);
    check("ksf_skip_rx", {11'd0, bus.io_skip}, 12'd1);
    iot_end();
    iot_setup(6'o03, 3'd4, 12'o7400);
    check("krs_avail", {11'd0, bus.io_data_avail}, 12'd1);
    check("krs_data", bus.io_data_out, 12'o7532);
    iot_end();
    iot_setup(6'o03, 3'd1, 12'd0);
    check("ksf_after_krs", {11'd0, bus.io_skip}, 12'd1);
    iot_end();
    iot_setup(6'o03, 3'd6, 12'o7777);
    check("krb_avail", {11'd0, bus.io_data_avail}, 12'd1);
    check("krb_data", bus.io_data_out, 12'o0132);
    iot_end();
    iot_setup(6'o03, 3'd1, 12'd0);
    check("ksf_after_krb", {11'd0, bus.io_skip}, 12'd0);
    iot_end();

    // Interrupt enable and printer skip/clear
    iot(6'o03, 3'd5, 12'd0);
    check("kie0_irq", {11'd0, bus.io_interrupt}, 12'd0);
    iot(6'o03, 3'd5, 12'd1);
    check("kie1_irq", {11'd0, bus.io_interrupt}, 12'd1);
    iot_setup(6'o04, 3'd5, 12'd0);
    check("tsk_skip", {11'd0, bus.io_skip}, 12'd1);
    iot_end();
    iot(6'o04, 3'd2, 12'd0);
    check("tcf_irq", {11'd0, bus.io_interrupt}, 12'd0);
    iot_setup(6'o04, 3'd5, 12'd0);
    check("tsk_after_tcf", {11'd0, bus.io_skip}, 12'd0);
    iot_end();
    iot_setup(6'o03, 3'd2, 12'o7777);
    check("kcc_avail", {11'd0, bus.io_data_avail}, 12'd1);
    check("kcc_data", bus.io_data_out, 12'd0);
    iot_end();

    // TPC 0125, then TLS 0377 while busy: flag cleared, load ignored
    iot(6'o04, 3'd4, 12'o0125);
    wait_ticks(1);
    iot(6'o04, 3'd0, 12'd0);
    iot_setup(6'o04, 3'd1, 12'd0);
    check("tfl_skip", {11'd0, bus.io_skip}, 12'd1);
    iot_end();
    iot(6'o04, 3'd6, 12'o0377);
    iot_setup(6'o04, 3'd1, 12'd0);
    check("tls_busy_clear", {11'd0, bus.io_skip}, 12'd0);
    iot_end();
    wait_ticks(40);
    check("tls_busy_ignored", {11'd0, uart_out}, 12'd0);
    wait_ticks(120);
    iot_setup(6'o04, 3'd1, 12'd0);
    check("tpc_done_skip", {11'd0, bus.io_skip}, 12'd1);
    iot_end();

    // Reset in the middle of a transmit
    iot(6'o03, 3'd5, 12'd0);
    iot(6'o04, 3'd4, 12'd0);
    wait_ticks(1);
    check("mid_tx_start", {11'd0, uart_out}, 12'd0);
    reset = 1'b0;
    #1;
    check("mid_tx_rst_out", {11'd0, uart_out}, 12'd1);
    check("mid_tx_rst_irq", {11'd0, bus.io_interrupt}, 12'd0);
    @(negedge clk);
    reset = 1'b1;
    iot_setup(6'o04, 3'd5, 12'd0);
    check("rst_tsk_skip", {11'd0, bus.io_skip}, 12'd0);
    iot_end();
    iot(6'o04, 3'd0, 12'd0);
    check("rst_int_en", {11'd0, bus.io_interrupt}, 12'd1);
    iot(6'o04, 3'd2, 12'd0);
    check("rst_tcf_irq", {11'd0, bus.io_interrupt}, 12'd0);

    // Short start glitch is rejected
    wait_ticks(1);
    uart_in = 1'b0;
    wait_ticks(3);
    uart_in = 1'b1;
    wait_ticks(200);
    iot_setup(6'o03, 3'd1, 12'd0);
    check("glitch_no_flag", {11'd0, bus.io_skip}, 12'd0);
    iot_end();

    // Framing error drops the byte
    send_frame(8'hA5, 1'b0);
    iot_setup(6'o03, 3'd1, 12'd0);
    check("stop0_no_flag", {11'd0, bus.io_skip}, 12'd0);
    iot_end();
    iot_setup(6'o03, 3'd4, 12'd0);
    check("stop0_rx_buf", bus.io_data_out, 12'd0);
    iot_end();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pdp8_tty_ctrl.md
Name: pdp8_tty_ctrl

Overview:
- Console teletype controller for the PDP-8 I/O subsystem, KL8E-style.
- Decodes keyboard (device 03) and printer (device 04) IOT instructions.
- Holds the keyboard/printer flags and the interrupt-enable bit.
- Drives a serial 8N1 UART (16x oversampled). It sits beside the clock and disk controllers and feeds the CPU's io mux with selected/data/skip/interrupt.

Parameters:
- KBD_DEV, 6'o03, keyboard device code.
- TTY_DEV, 6'o04, printer device code.
- IOT_EXEC_STATE, 4'd1, CPU state value in which IOT side effects commit.
- OVERSAMPLE, 16, brgclk ticks per serial bit.

Ports:
- clk, input, 1, single system clock.
- reset, input, 1, asynchronous active-low reset.
- brgclk, input, 1, baud-rate enable: one-clk-wide pulse synchronous to clk, at 16x the bit rate. It is not a clock.
- iot, input, 1, CPU is executing an IOT.
- state, input, 4, CPU major state.
- mb, input, 12, memory buffer. mb[2:0] is the operation field (mb[0] is PDP bit 11).
- io_select, input, 6, device code, equal to mb[8:3].
- io_data_in, input, 12, current AC.
- io_selected, output, 1, iot & (io_select is KBD_DEV or TTY_DEV).
- io_data_out, output, 12, value that replaces AC when io_data_avail=1.
- io_data_avail, output, 1, AC load strobe (combinational).
- io_interrupt, output, 1, interrupt request.
- io_skip, output, 1, skip request (combinational).
- uart_in, input, 1, serial receive (asynchronous).
- uart_out, output, 1, serial transmit. Idle level is 1.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low.
- Reset values: rx_flag=0, tx_flag=0, int_en=1, rx_buf=0, tx idle, uart_out=1, rx idle.
- Combinational outputs are nonzero only while io_selected=1.
- Flag/buffer side effects commit on the clk edge where iot=1, state==IOT_EXEC_STATE and the device is selected. Each IOT commits exactly once.
- Keyboard IOTs (operation field mb[2:0]):
  - 0 KCF: clear rx_flag.
  - 1 KSF: io_skip=rx_flag.
  - 2 KCC: clear rx_flag; data_avail=1, data_out=0.
  - 4 KRS: data_avail=1, data_out=io_data_in | {4'b0, rx_buf}.
  - 5 KIE: int_en <= io_data_in[0].
  - 6 KRB: clear rx_flag; data_avail=1, data_out={4'b0, rx_buf}.
  - 3, 7: no effect.
- Printer IOTs:
  - 0 TFL: set tx_flag.
  - 1 TSF: io_skip=tx_flag.
  - 2 TCF: clear tx_flag.
  - 4 TPC: load tx_buf=io_data_in[7:0] and start transmit.
  - 5 TSK: io_skip=rx_flag | tx_flag.
  - 6 TLS: clear tx_flag, load, start.
  - 3, 7: no effect.
  - Printer IOTs never assert data_avail.
- io_interrupt = int_en & (rx_flag | tx_flag). Registered.
- Transmitter:
  - Frame is start(0), 8 data bits LSB first, stop(1). Each bit lasts OVERSAMPLE brgclk ticks.
  - Transmission starts at the next brgclk tick after the load.
  - tx_flag is set on the tick that ends the stop bit.
  - A load while busy is ignored.
  - TLS clears tx_flag even when the load is ignored.
- Receiver:
  - uart_in passes through a 2-flop synchronizer.
  - A falling edge starts the frame. The start bit is re-checked at tick 8 and aborted if high.
  - Data bits are sampled at bit midpoints.
  - The stop bit is sampled at its midpoint. If stop=1, rx_buf<=byte and rx_flag<=1. If stop=0, the frame is dropped.
  - A new byte overwrites rx_buf regardless of rx_flag (overrun, no error flag).
- Simultaneous events: a UART set and an IOT clear of the same flag in the same cycle resolve to set.
- Both paths are idle when brgclk=0.

Decomposition:
- Shared package pdp8_io_pkg:
  - Device codes.
  - IOT operation encodings (KCF..KRB, TFL..TLS).
  - CPU state encodings, including IOT_EXEC_STATE.
- One natural sub-module, pdp8_uart8n1: brgclk-enabled TX/RX.
  - Outputs: tx_busy, tx_done pulse, rx_data, rx_valid pulse.
- The controller holds the IOT decode, flags and int_en.

Test Plan:
- Reset → uart_out=1, io_interrupt=1? No: flags are 0, so io_interrupt=0. io_skip=0 for KSF/TSF.
- TLS with AC=12'o0101 → uart_out sends 0,1,0,0,0,0,0,1,0,1 (160 ticks). tx_flag then rises, TSF skips, io_interrupt=1.
- Drive serial 0x5A on uart_in → rx_flag=1. KSF skips. KRB gives data_avail=1, data_out=12'o0132, and rx_flag clears.
- KRS with AC=12'o7400 and rx_buf=0x5A → data_out=12'o7532. rx_flag is unchanged.
- KIE with AC=0 and tx_flag=1 → io_interrupt=0. KIE with AC=1 → io_interrupt=1. TSK skips; TCF then TSK does not skip.
- Assert reset mid-transmit → uart_out=1 immediately. Flags are 0 and int_en=1. A frame with stop=0 leaves rx_flag=0.
